// File: rtl/width_conv_pkg.sv
// Shared sizing helpers for the width-converting FIFO: narrow-word width,
// slices per input/output word and the default statistics counter width.
package width_conv_pkg;

    localparam int CNT_WIDTH_DEF = 32'sd32;

    function automatic int clog2_f(input int value);
        int res;
        int pow;
        res = 32'sd0;
        pow = 32'sd1;
        while (pow < value) begin
            pow = pow * 32'sd2;
            res = res + 32'sd1;
        end
        return res;
    endfunction

    function automatic int nw_f(input int in_w, input int out_w);
        return (in_w < out_w) ? in_w : out_w;
    endfunction

    function automatic int ratio_f(input int in_w, input int out_w);
        return (in_w < out_w) ? (out_w / in_w) : (in_w / out_w);
    endfunction

    function automatic int wi_f(input int in_w, input int out_w);
        return in_w / nw_f(in_w, out_w);
    endfunction

    function automatic int wo_f(input int in_w, input int out_w);
        return out_w / nw_f(in_w, out_w);
    endfunction

    function automatic bit is_pow2_f(input int value);
        return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
    endfunction

endpackage

// File: rtl/width_conv_fifo_if.sv
// Valid/ready stream pair around the width-converting FIFO: side a is the
// wide/narrow producer input, side b the converted output.
interface width_conv_fifo_if #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
);
    logic [IN_WIDTH-1:0]  d_a;
    logic                 vld_a;
    logic                 rdy_a;
    logic [OUT_WIDTH-1:0] d_b;
    logic                 vld_b;
    logic                 rdy_b;

    modport master (output d_a, vld_a, rdy_b, input rdy_a, d_b, vld_b);
    modport slave  (input d_a, vld_a, rdy_b, output rdy_a, d_b, vld_b);
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; en gates counting.
module sat_counter
    import width_conv_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_r;

    // Count qualifying cycles, saturating at the maximum value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (en && inc && (count_r != {CNT_WIDTH{1'b1}})) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/width_conv_fifo.sv
// Single-clock width-converting FIFO over a ring of NW-bit words, with flush,
// occupancy and saturating stall/throughput statistics.
module width_conv_fifo
    import width_conv_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    width_conv_fifo_if.slave           io,
    input  logic                       flush,
    input  logic                       is_done_mode_user,
    output logic [clog2_f(DEPTH):0]    level,
    output logic [CNT_WIDTH-1:0]       full_cnt,
    output logic [CNT_WIDTH-1:0]       empty_cnt,
    output logic [CNT_WIDTH-1:0]       read_cnt,
    output logic                       stall_condition
);

    localparam int NW = nw_f(IN_WIDTH, OUT_WIDTH);
    localparam int R  = ratio_f(IN_WIDTH, OUT_WIDTH);
    localparam int WI = wi_f(IN_WIDTH, OUT_WIDTH);
    localparam int WO = wo_f(IN_WIDTH, OUT_WIDTH);
    localparam int AW = clog2_f(DEPTH);
    localparam int LW = AW + 1;

    generate
        if ((IN_WIDTH % NW) != 0 || (OUT_WIDTH % NW) != 0) begin : g_bad_width
            $error("width_conv_fifo: IN_WIDTH and OUT_WIDTH must be multiples of the narrow width");
        end
        if (!is_pow2_f(DEPTH)) begin : g_bad_depth_pow2
            $error("width_conv_fifo: DEPTH must be a power of two");
        end
        if (DEPTH < 2 * R) begin : g_bad_depth_min
            $error("width_conv_fifo: DEPTH must be at least twice the width ratio");
        end
    endgenerate

    logic [NW-1:0]        mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;
    logic [LW-1:0]        level_next_s;
    logic [LW-1:0]        free_s;
    logic                 rdy_a_s;
    logic                 vld_b_s;
    logic                 wr_en_s;
    logic                 rd_en_s;
    logic [OUT_WIDTH-1:0] d_b_s;

    // Handshake qualification from the start-of-cycle occupancy only
    always_comb begin
        free_s       = LW'(DEPTH) - level_r;
        rdy_a_s      = (free_s >= LW'(WI)) && !flush;
        vld_b_s      = (level_r >= LW'(WO)) && !flush;
        wr_en_s      = io.vld_a && rdy_a_s;
        rd_en_s      = vld_b_s && io.rdy_b;
        level_next_s = level_r;
        if (wr_en_s) begin
            level_next_s = level_next_s + LW'(WI);
        end else begin
            level_next_s = level_next_s;
        end
        if (rd_en_s) begin
            level_next_s = level_next_s - LW'(WO);
        end else begin
            level_next_s = level_next_s;
        end
    end

    // Scatter the accepted input word into consecutive slots, lowest slice first
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < WI; k++) begin
                mem_r[wr_ptr_r + AW'(k)] <= io.d_a[k*NW +: NW];
            end
        end
    end

    // Pointer and occupancy state; flush clears it at the clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            wr_ptr_r <= wr_en_s ? (wr_ptr_r + AW'(WI)) : wr_ptr_r;
            rd_ptr_r <= rd_en_s ? (rd_ptr_r + AW'(WO)) : rd_ptr_r;
            level_r  <= level_next_s;
        end
    end

    // Gather WO slots from the read pointer; the oldest slot lands in the LSBs
    always_comb begin
        d_b_s = {OUT_WIDTH{1'b0}};
        for (int j = 0; j < WO; j++) begin
            d_b_s[j*NW +: NW] = mem_r[rd_ptr_r + AW'(j)];
        end
    end

    assign io.rdy_a        = rdy_a_s;
    assign io.vld_b        = vld_b_s;
    assign io.d_b          = d_b_s;
    assign level           = level_r;
    assign stall_condition = io.vld_a && !rdy_a_s;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_full_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (io.vld_a && !rdy_a_s),
        .en    (!is_done_mode_user),
        .count (full_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_empty_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (io.rdy_b && !vld_b_s),
        .en    (!is_done_mode_user),
        .count (empty_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_read_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_en_s),
        .en    (!is_done_mode_user),
        .count (read_cnt)
    );

endmodule
